pixel_frame_parser: RTL and testbench

- Sits between rxuart and the pixel colour store/sequencer.
- Consumes the UART byte stream (rx_byte/rx_valid) and decodes framed pixel-write commands.
- Each accepted frame yields a one-cycle write strobe (index, R, G, B) into the colour arrays, or a refresh pulse that starts a chain update.
- Replaces the current "byte overwrites pixel 0" path.

---
 rtl/pixel_pkg.sv | 34 +++
 rtl/byte_timeout.sv | 31 +++
 rtl/pixel_frame_parser.sv | 144 ++++++++++++++
 tb/tb_pixel_frame_parser.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/pixel_pkg.sv
// rtl/pixel_pkg.sv - shared types and constants for the UART pixel command path
package pixel_pkg;

    localparam logic [7:0] SYNC_BYTE_DEF   = 8'hA5;
    localparam logic [7:0] REFRESH_IDX_DEF = 8'hFF;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_IDX  = 3'd1;
    localparam logic [2:0] S_GRN  = 3'd2;
    localparam logic [2:0] S_RED  = 3'd3;
    localparam logic [2:0] S_BLU  = 3'd4;
    localparam logic [2:0] S_CHK  = 3'd5;

    typedef enum logic [2:0] {
        IDLE = S_IDLE,
        IDX  = S_IDX,
        GRN  = S_GRN,
        RED  = S_RED,
        BLU  = S_BLU,
        CHK  = S_CHK
    } pixel_state_e;

    // GRB field order matches the WS2812 wire order
    typedef struct packed {
        logic [7:0] g;
        logic [7:0] r;
        logic [7:0] b;
    } rgb_t;

    function automatic logic [7:0] frame_chk(input logic [7:0] idx, input rgb_t p);
        return idx ^ p.g ^ p.r ^ p.b;
    endfunction

endpackage

// File: rtl/byte_timeout.sv
// rtl/byte_timeout.sv - inter-byte idle counter with clear/enable and terminal-count pulse
module byte_timeout #(
    parameter int TC = 120000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_tc
);

    localparam int CW = $clog2(TC + 1);

    logic [CW-1:0] r_count;
    logic          w_tc;

    // A clear in the same cycle suppresses the pulse, so an arriving byte always wins
    assign w_tc = i_enable && !i_clear && (r_count == CW'(TC - 1));
    assign o_tc = w_tc;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_clear || !i_enable || w_tc) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/pixel_frame_parser.sv
// rtl/pixel_frame_parser.sv - decodes framed UART pixel writes; PIXEL_PARSER_CHECKSUM_EN adds the CHK byte
module pixel_frame_parser
    import pixel_pkg::*;
#(
    parameter int          NUM_PIXELS     = 10,
    parameter int          AW             = 4,
    parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEF,
    parameter logic [7:0]  REFRESH_IDX    = REFRESH_IDX_DEF,
    parameter int          TIMEOUT_CYCLES = 120000
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [7:0]    i_rx_byte,
    input  logic          i_rx_valid,
    output logic          o_wr_en,
    output logic [AW-1:0] o_wr_addr,
    output logic [7:0]    o_wr_r,
    output logic [7:0]    o_wr_g,
    output logic [7:0]    o_wr_b,
    output logic          o_refresh,
    output logic          o_err,
    output logic [7:0]    o_err_count
);

    localparam logic [7:0] NUM_PIXELS_B = 8'(NUM_PIXELS);

    pixel_state_e  r_state;
    logic [7:0]    r_idx;
    logic [7:0]    r_g;
    logic [7:0]    r_r;
`ifdef PIXEL_PARSER_CHECKSUM_EN
    logic [7:0]    r_b;
`endif
    logic          r_wr_en;
    logic [AW-1:0] r_wr_addr;
    rgb_t          r_wr_pix;
    logic          r_refresh;
    logic          r_err;
    logic [7:0]    r_err_count;

    rgb_t          w_pix;
    logic          w_last;
    logic          w_chk_ok;
    logic          w_do_write;
    logic          w_do_refresh;
    logic          w_do_err;
    logic          w_tc;

    byte_timeout #(
        .TC(TIMEOUT_CYCLES)
    ) u_byte_timeout (
        .i_clk    (CLK),
        .i_rst    (RST),
        .i_clear  (i_rx_valid),
        .i_enable (r_state != IDLE),
        .o_tc     (w_tc)
    );

`ifdef PIXEL_PARSER_CHECKSUM_EN
    assign w_pix    = '{g: r_g, r: r_r, b: r_b};
    assign w_last   = i_rx_valid && (r_state == CHK);
    assign w_chk_ok = (frame_chk(r_idx, w_pix) == i_rx_byte);
`else
    assign w_pix    = '{g: r_g, r: r_r, b: i_rx_byte};
    assign w_last   = i_rx_valid && (r_state == BLU);
    assign w_chk_ok = 1'b1;
`endif

    // Refresh takes precedence so a REFRESH_IDX inside the pixel range never writes
    assign w_do_refresh = w_last && w_chk_ok && (r_idx == REFRESH_IDX);
    assign w_do_write   = w_last && w_chk_ok && (r_idx != REFRESH_IDX) && (r_idx < NUM_PIXELS_B);
    assign w_do_err     = (w_last && !w_do_write && !w_do_refresh) || w_tc;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_g         <= '0;
            r_r         <= '0;
`ifdef PIXEL_PARSER_CHECKSUM_EN
            r_b         <= '0;
`endif
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_pix    <= '0;
            r_refresh   <= 1'b0;
            r_err       <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_wr_en   <= w_do_write;
            r_refresh <= w_do_refresh;
            r_err     <= w_do_err;

            if (w_do_write) begin
                r_wr_addr <= r_idx[AW-1:0];
                r_wr_pix  <= w_pix;
            end

            if (w_do_err && (r_err_count != 8'hFF)) begin
                r_err_count <= r_err_count + 8'd1;
            end

            if (i_rx_valid) begin
                case (r_state)
                    IDLE: if (i_rx_byte == SYNC_BYTE) r_state <= IDX;
                    IDX: begin
                        r_idx   <= i_rx_byte;
                        r_state <= GRN;
                    end
                    GRN: begin
                        r_g     <= i_rx_byte;
                        r_state <= RED;
                    end
                    RED: begin
                        r_r     <= i_rx_byte;
                        r_state <= BLU;
                    end
`ifdef PIXEL_PARSER_CHECKSUM_EN
                    BLU: begin
                        r_b     <= i_rx_byte;
                        r_state <= CHK;
                    end
                    CHK:     r_state <= IDLE;
`else
                    BLU:     r_state <= IDLE;
`endif
                    default: r_state <= IDLE;
                endcase
            end else if (w_tc) begin
                r_state <= IDLE;
            end
        end
    end

    assign o_wr_en     = r_wr_en;
    assign o_wr_addr   = r_wr_addr;
    assign o_wr_g      = r_wr_pix.g;
    assign o_wr_r      = r_wr_pix.r;
    assign o_wr_b      = r_wr_pix.b;
    assign o_refresh   = r_refresh;
    assign o_err       = r_err;
    assign o_err_count = r_err_count;

endmodule

// File: tb/tb_pixel_frame_parser.sv
// tb/tb_pixel_frame_parser.sv - scoreboard bench for pixel_frame_parser
module tb_pixel_frame_parser;

    localparam int NP = 10;
    localparam int AW = 4;
    localparam int TO = 40;

    localparam int K_WR  = 0;
    localparam int K_REF = 1;
    localparam int K_ERR = 2;

    typedef struct {
        int         kind;
        logic [7:0] addr;
        logic [7:0] g;
        logic [7:0] r;
        logic [7:0] b;
        logic [7:0] cnt;
    } exp_t;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic [7:0]    i_rx_byte = 8'h00;
    logic          i_rx_valid = 1'b0;
    logic          o_wr_en;
    logic [AW-1:0] o_wr_addr;
    logic [7:0]    o_wr_r;
    logic [7:0]    o_wr_g;
    logic [7:0]    o_wr_b;
    logic          o_refresh;
    logic          o_err;
    logic [7:0]    o_err_count;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   m_err = 0;

    pixel_frame_parser #(
        .NUM_PIXELS     (NP),
        .AW             (AW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .i_rx_byte   (i_rx_byte),
        .i_rx_valid  (i_rx_valid),
        .o_wr_en     (o_wr_en),
        .o_wr_addr   (o_wr_addr),
        .o_wr_r      (o_wr_r),
        .o_wr_g      (o_wr_g),
        .o_wr_b      (o_wr_b),
        .o_refresh   (o_refresh),
        .o_err       (o_err),
        .o_err_count (o_err_count)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    always @(negedge CLK) begin
        if (!RST && (o_wr_en || o_refresh || o_err)) begin
            int   k;
            exp_t e;
            k = (32'(o_wr_en) + 32'(o_refresh) + 32'(o_err) > 1) ? 3 :
                o_wr_en ? K_WR : (o_refresh ? K_REF : K_ERR);
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", 64'(k), 64'hDEAD);
            end else begin
                e = exp_q.pop_front();
                check("strobe_kind", 64'(k), 64'(e.kind));
                if (e.kind == K_WR) begin
                    check("wr_addr", 64'(o_wr_addr), 64'(e.addr));
                    check("wr_grb", {40'd0, o_wr_g, o_wr_r, o_wr_b}, {40'd0, e.g, e.r, e.b});
                end
                check("err_count", 64'(o_err_count), 64'(e.cnt));
            end
        end
    end

    task automatic expect_ev(input int kind, input logic [7:0] addr,
                             input logic [7:0] g, input logic [7:0] r, input logic [7:0] b);
        exp_t e;
        if (kind == K_ERR && m_err < 255) m_err++;
        e.kind = kind; e.addr = addr; e.g = g; e.r = r; e.b = b; e.cnt = 8'(m_err);
        exp_q.push_back(e);
    endtask

    // Called at posedge+1; consecutive calls produce back-to-back strobes
    task automatic send_byte(input logic [7:0] v);
        i_rx_byte  = v;
        i_rx_valid = 1'b1;
        @(posedge CLK); #1;
        i_rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge CLK); #1;
        end
    endtask

    task automatic frame(input logic [7:0] idx, input logic [7:0] g, input logic [7:0] r,
                         input logic [7:0] b, input logic [7:0] chk, input int gap);
        send_byte(8'hA5); idle(gap);
        send_byte(idx);   idle(gap);
        send_byte(g);     idle(gap);
        send_byte(r);     idle(gap);
        send_byte(b);
`ifdef PIXEL_PARSER_CHECKSUM_EN
        idle(gap);
        send_byte(chk);
`else
        if (chk == 8'h00) idle(0);
`endif
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(posedge CLK); #1;
            n++;
        end
        check(name, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    initial begin
        #12;
        check("reset_outputs", {o_wr_en, o_refresh, o_err, o_err_count, 4'(o_wr_addr), o_wr_g, o_wr_r, o_wr_b},
              64'd0);
        @(posedge CLK); #1;
        RST = 1'b0;
        idle(2);

        expect_ev(K_WR, 8'd3, 8'h10, 8'h20, 8'h30);
        frame(8'h03, 8'h10, 8'h20, 8'h30, 8'h03, 0);
        drain("drain_write3");

`ifdef PIXEL_PARSER_CHECKSUM_EN
        expect_ev(K_ERR, 8'd0, 8'h00, 8'h00, 8'h00);
`else
        expect_ev(K_WR, 8'd2, 8'h10, 8'h20, 8'h30);
`endif
        frame(8'h02, 8'h10, 8'h20, 8'h30, 8'h00, 0);
        drain("drain_badchk");

        expect_ev(K_REF, 8'd0, 8'h00, 8'h00, 8'h00);
        frame(8'hFF, 8'h00, 8'h00, 8'h00, 8'hFF, 0);
        drain("drain_refresh");

        expect_ev(K_ERR, 8'd0, 8'h00, 8'h00, 8'h00);
        frame(8'h0A, 8'h01, 8'h02, 8'h03, 8'h0A, 0);
        expect_ev(K_WR, 8'd9, 8'h11, 8'h22, 8'h33);
        frame(8'h09, 8'h11, 8'h22, 8'h33, 8'h09, 0);
        drain("drain_range_then_9");

        // Longest legal gap before each byte: byte arrives on the timeout cycle
        expect_ev(K_WR, 8'd7, 8'h44, 8'h55, 8'h66);
        frame(8'h07, 8'h44, 8'h55, 8'h66, 8'h07 ^ 8'h44 ^ 8'h55 ^ 8'h66, TO - 1);
        drain("drain_gap_edge");

        expect_ev(K_ERR, 8'd0, 8'h00, 8'h00, 8'h00);
        send_byte(8'hA5); send_byte(8'h05); send_byte(8'h11);
        idle(TO + 3);
        drain("drain_timeout");
        send_byte(8'h22); send_byte(8'h33);
        idle(3);
        check("post_timeout_ignored", 64'(o_err_count), 64'(m_err));

        send_byte(8'h00); send_byte(8'hA4);
        idle(3);
        check("stray_no_err", 64'(o_err_count), 64'(m_err));
        expect_ev(K_WR, 8'd1, 8'h0A, 8'h0B, 8'h0C);
        frame(8'h01, 8'h0A, 8'h0B, 8'h0C, 8'h01 ^ 8'h0A ^ 8'h0B ^ 8'h0C, 0);
        drain("drain_after_stray");

        for (int i = 0; i < 300; i++) begin
            expect_ev(K_ERR, 8'd0, 8'h00, 8'h00, 8'h00);
            frame(8'h20, 8'h00, 8'h00, 8'h00, 8'h20, 0);
        end
        drain("drain_sat");
        check("err_count_sat", 64'(o_err_count), 64'd255);

        send_byte(8'hA5); send_byte(8'h04);
        #2 RST = 1'b1;
        #1 check("mid_reset_outputs",
                 {o_wr_en, o_refresh, o_err, o_err_count, 4'(o_wr_addr), o_wr_g, o_wr_r, o_wr_b}, 64'd0);
        @(posedge CLK); #1;
        RST = 1'b0;
        m_err = 0;
        send_byte(8'h10); send_byte(8'h20); send_byte(8'h30); send_byte(8'h04);
        idle(3);
        check("post_reset_quiet", {o_err_count, 7'd0, o_wr_en}, 16'd0);
        expect_ev(K_WR, 8'd9, 8'h11, 8'h22, 8'h33);
        frame(8'h09, 8'h11, 8'h22, 8'h33, 8'h09, 0);
        drain("drain_after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1);
    end

endmodule
